smac_vol_seq: RTL and testbench
===============================

Name: smac_vol_seq

Overview:
- Parametrised successor to the 3x3 conv-volume controller for the SMAC engine.
- Sequences bit-serial weight x activation accumulation over a KxK tap window, then writes back one result per filter, for a runtime-selected number of filters and weight precision.
- All counters are internal; upstream supplies only a start pulse, the core_stall_n handshake and a write-back ack.
- Sits between the activation/weight fetch logic and the SMAC datapath (accumulators, negation stage, ReLU/write-back).

Parameters:
- KERNEL, 3, kernel side; TAPS = KERNEL*KERNEL.
- W_BITS_MAX, 8, maximum weight precision in bits (>=2).
- MAX_FIL, 64, maximum filters per activation load.
- PIPE_DEPTH, 3, datapath pipeline depth; sets prime and drain length (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; sampled only in IDLE.
- cfg_wbits  in  $clog2(W_BITS_MAX+1)  weight precision; latched at start.
- cfg_nfil  in  $clog2(MAX_FIL+1)  filter count; latched at start.
- core_stall_n  in  1  handshake; 1 = the core may advance this cycle.
- wb_ack  in  1  write-back consumer accepted the result.
- act_load  out  1  load a new activation volume.
- wei_load  out  1  fetch the next weight bit-slice.
- acc_en  out  1  accumulate enable, stage 1.
- acc_clr  out  1  clear accumulators.
- neg_en  out  1  MSB weight bit is active (two's-complement subtract).
- wb  out  1  result valid for write-back.
- done  out  1  one-cycle completion pulse.
- busy  out  1  not in IDLE.
- bit_idx  out  $clog2(W_BITS_MAX)  current weight bit.
- tap_idx  out  $clog2(TAPS)  current tap.
- fil_idx  out  $clog2(MAX_FIL)  current filter.

Behaviour:
- Output timing: outputs are combinational decodes of registered state/counters, plus core_stall_n where noted. Only handshake-gated states depend on core_stall_n.
- Reset: asynchronous; state=IDLE and all counters=0.
  - Reset values: acc_clr=1 (IDLE decode); every other output 0.
  - Reset mid-operation aborts immediately: no done, no wb.
- Config latch at start:
  - cfg_wbits of 0 or >W_BITS_MAX is clamped to W_BITS_MAX; the effective value is B.
  - cfg_nfil of 0 is treated as 1; >MAX_FIL is clamped to MAX_FIL; the effective value is F.
  - Later cfg changes are ignored until the next IDLE.
- IDLE: acc_clr=1. If start=1, latch config, clear counters, go to LOAD_ACT. start outside IDLE is ignored.
- LOAD_ACT: if core_stall_n, act_load=1 and go to PRIME; otherwise hold.
- PRIME: if core_stall_n, wei_load=1 and prime_cnt++. When prime_cnt=PIPE_DEPTH-1 with core_stall_n, go to ACCUM.
- ACCUM:
  - If core_stall_n: wei_load=1, acc_en=1, neg_en=(bit_idx==B-1).
  - bit_idx wraps at B-1 and increments tap_idx.
  - On the wrap with tap_idx=TAPS-1, go to DRAIN.
  - core_stall_n=0: all strobes 0, counters hold.
- DRAIN: exactly PIPE_DEPTH cycles with acc_en=1, not gated by core_stall_n; then go to WRITE_BACK.
- WRITE_BACK: wb=1 and hold until wb_ack (ack is accepted in the same cycle wb rises); core_stall_n is ignored. On ack:
  - if fil_idx=F-1, go to FINISH;
  - otherwise fil_idx++, pulse acc_clr=1, go to PRIME (activations are reused, no reload).
- FINISH: done=1 for one cycle, go to IDLE.
- Indices: bit_idx, tap_idx and fil_idx are 0 outside ACCUM/WRITE_BACK except where specified; tap_idx/bit_idx reset to 0 on each PRIME entry.
- Latency with no stalls and immediate ack, counting the start cycle as cycle 0:
  - done in cycle 1 + F*(2*PIPE_DEPTH + TAPS*B + 1) + 1.
- B=1: every ACCUM cycle has neg_en=1 (sign-only weights).

Optional Feature:
- Macro: SMAC_SEQ_PERF_EN.
- With the macro defined, add two outputs, both cleared on start and saturating at all-ones:
  - stall_cycles [31:0]: counts cycles with core_stall_n=0 in LOAD_ACT/PRIME/ACCUM;
  - wb_wait_cycles [31:0]: counts WRITE_BACK cycles without wb_ack.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package smac_seq_pkg holds:
  - the state enum (IDLE, LOAD_ACT, PRIME, ACCUM, DRAIN, WRITE_BACK, FINISH);
  - the clamp functions for cfg_wbits/cfg_nfil;
  - localparam width helpers.
- One natural sub-module, smac_wrap_cnt: an enabled counter with a runtime terminal value, clear, and wrap flag. It is instantiated for the bit, tap, filter and prime/drain counters.

Test Plan:
- KERNEL=3, PIPE_DEPTH=3, cfg_wbits=4, cfg_nfil=2, core_stall_n=1, wb_ack tied 1, start at cycle 0 -> act_load in cycle 1; 72 acc_en cycles in ACCUM; 18 neg_en cycles; wb in cycles 44 and 87; done in cycle 88 only.
- Same config, core_stall_n=0 for 5 cycles mid-ACCUM and 2 cycles in DRAIN -> counters and strobes freeze for exactly 5 cycles; DRAIN is unaffected; done in cycle 93.
- cfg_wbits=0, cfg_nfil=0 -> B=8, F=1; 72 ACCUM cycles, 9 neg_en cycles; done in cycle 1+79+1=81.
- wb_ack held low 10 cycles in filter 0 -> wb stays high 11 cycles; fil_idx stays 0 until ack; acc_clr pulses on ack.
- rst asserted mid-ACCUM, start retried -> immediate IDLE with acc_clr=1 and indices 0; no done; the restarted run has nominal latency. start during busy is ignored.
- SMAC_SEQ_PERF_EN defined, scenario 2 -> stall_cycles=5, wb_wait_cycles=0.

Source files
------------

// File: rtl/smac_seq_pkg.sv
// Shared types and helpers for the SMAC conv-volume sequencer (smac_vol_seq).
package smac_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD_ACT   = 3'd1,
      ST_PRIME      = 3'd2,
      ST_ACCUM      = 3'd3,
      ST_DRAIN      = 3'd4,
      ST_WRITE_BACK = 3'd5,
      ST_FINISH     = 3'd6
   } state_e;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      if (n < 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(n);
      end
   endfunction

   function automatic int unsigned clamp_wbits(input int unsigned v, input int unsigned vmax);
      if ((v == 32'd0) || (v > vmax)) begin
         return vmax;
      end else begin
         return v;
      end
   endfunction

   function automatic int unsigned clamp_nfil(input int unsigned v, input int unsigned vmax);
      if (v == 32'd0) begin
         return 32'd1;
      end else if (v > vmax) begin
         return vmax;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/smac_wrap_cnt.sv
// Enabled up-counter with runtime terminal value; wraps to zero and flags the wrap cycle.
module smac_wrap_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap = en && (cnt_q == term);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/smac_vol_seq.sv
// KxK bit-serial conv-volume sequencer for the SMAC engine.
// Defining SMAC_SEQ_PERF_EN adds the stall_cycles / wb_wait_cycles counters.
module smac_vol_seq
   import smac_seq_pkg::*;
#(
   parameter int unsigned KERNEL     = 3,
   parameter int unsigned W_BITS_MAX = 8,
   parameter int unsigned MAX_FIL    = 64,
   parameter int unsigned PIPE_DEPTH = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [cnt_w(W_BITS_MAX+32'd1)-1:0]   cfg_wbits,
   input  logic [cnt_w(MAX_FIL+32'd1)-1:0]      cfg_nfil,
   input  logic                                 core_stall_n,
   input  logic                                 wb_ack,
   output logic                                 act_load,
   output logic                                 wei_load,
   output logic                                 acc_en,
   output logic                                 acc_clr,
   output logic                                 neg_en,
   output logic                                 wb,
   output logic                                 done,
   output logic                                 busy,
   output logic [cnt_w(W_BITS_MAX)-1:0]         bit_idx,
   output logic [cnt_w(KERNEL*KERNEL)-1:0]      tap_idx,
   output logic [cnt_w(MAX_FIL)-1:0]            fil_idx
`ifdef SMAC_SEQ_PERF_EN
   ,
   output logic [31:0]                          stall_cycles,
   output logic [31:0]                          wb_wait_cycles
`endif
);

   localparam int unsigned TAPS  = KERNEL * KERNEL;
   localparam int unsigned BIT_W = cnt_w(W_BITS_MAX);
   localparam int unsigned TAP_W = cnt_w(TAPS);
   localparam int unsigned FIL_W = cnt_w(MAX_FIL);
   localparam int unsigned PD_W  = cnt_w(PIPE_DEPTH);

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 32'd1);
   localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PIPE_DEPTH - 32'd1);

   state_e state_q, state_d;
   logic [BIT_W-1:0] b_last_q, b_last_d;
   logic [FIL_W-1:0] f_last_q, f_last_d;

   logic start_s;
   logic bit_en_s, bit_wrap_s, tap_wrap_s, fil_en_s, fil_wrap_s, pd_en_s, pd_wrap_s;
   logic [BIT_W-1:0] bit_cnt_s;
   logic [TAP_W-1:0] tap_cnt_s;
   logic [FIL_W-1:0] fil_cnt_s;
   logic [PD_W-1:0]  pd_cnt_s;

   assign start_s  = (state_q == ST_IDLE) && start;
   assign bit_en_s = (state_q == ST_ACCUM) && core_stall_n;
   assign fil_en_s = (state_q == ST_WRITE_BACK) && wb_ack;
   // One counter serves both PRIME (stall-gated) and DRAIN (free-running).
   assign pd_en_s  = ((state_q == ST_PRIME) && core_stall_n) || (state_q == ST_DRAIN);

   smac_wrap_cnt #(.W(BIT_W)) u_bit_cnt (
      .clk(clk), .rst(rst), .clr(start_s), .en(bit_en_s),
      .term(b_last_q), .cnt(bit_cnt_s), .wrap(bit_wrap_s)
   );

   smac_wrap_cnt #(.W(TAP_W)) u_tap_cnt (
      .clk(clk), .rst(rst), .clr(start_s), .en(bit_wrap_s),
      .term(TAP_LAST), .cnt(tap_cnt_s), .wrap(tap_wrap_s)
   );

   smac_wrap_cnt #(.W(FIL_W)) u_fil_cnt (
      .clk(clk), .rst(rst), .clr(start_s), .en(fil_en_s),
      .term(f_last_q), .cnt(fil_cnt_s), .wrap(fil_wrap_s)
   );

   smac_wrap_cnt #(.W(PD_W)) u_pd_cnt (
      .clk(clk), .rst(rst), .clr(start_s), .en(pd_en_s),
      .term(PD_LAST), .cnt(pd_cnt_s), .wrap(pd_wrap_s)
   );

   assign bit_idx = bit_cnt_s;
   assign tap_idx = tap_cnt_s;
   assign fil_idx = fil_cnt_s;
   assign busy    = (state_q != ST_IDLE);

   always_comb begin
      b_last_d = b_last_q;
      f_last_d = f_last_q;
      if (start_s) begin
         b_last_d = BIT_W'(clamp_wbits(32'(cfg_wbits), W_BITS_MAX) - 32'd1);
         f_last_d = FIL_W'(clamp_nfil(32'(cfg_nfil), MAX_FIL) - 32'd1);
      end else begin
         b_last_d = b_last_q;
         f_last_d = f_last_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      act_load = 1'b0;
      wei_load = 1'b0;
      acc_en   = 1'b0;
      acc_clr  = 1'b0;
      neg_en   = 1'b0;
      wb       = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            acc_clr = 1'b1;
            if (start) begin
               state_d = ST_LOAD_ACT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_ACT: begin
            if (core_stall_n) begin
               act_load = 1'b1;
               state_d  = ST_PRIME;
            end else begin
               state_d  = ST_LOAD_ACT;
            end
         end
         ST_PRIME: begin
            if (core_stall_n) begin
               wei_load = 1'b1;
               if (pd_wrap_s) begin
                  state_d = ST_ACCUM;
               end else begin
                  state_d = ST_PRIME;
               end
            end else begin
               state_d = ST_PRIME;
            end
         end
         ST_ACCUM: begin
            if (core_stall_n) begin
               wei_load = 1'b1;
               acc_en   = 1'b1;
               neg_en   = (bit_cnt_s == b_last_q);
               if (tap_wrap_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            acc_en = 1'b1;
            if (pd_wrap_s) begin
               state_d = ST_WRITE_BACK;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_WRITE_BACK: begin
            wb = 1'b1;
            if (wb_ack) begin
               if (fil_wrap_s) begin
                  state_d = ST_FINISH;
               end else begin
                  acc_clr = 1'b1;
                  state_d = ST_PRIME;
               end
            end else begin
               state_d = ST_WRITE_BACK;
            end
         end
         ST_FINISH: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         b_last_q <= '0;
         f_last_q <= '0;
      end else begin
         state_q  <= state_d;
         b_last_q <= b_last_d;
         f_last_q <= f_last_d;
      end
   end

`ifdef SMAC_SEQ_PERF_EN
   logic [31:0] stall_q, stall_d, wbw_q, wbw_d;
   logic        stall_ev_s, wbw_ev_s;

   assign stall_ev_s = !core_stall_n && ((state_q == ST_LOAD_ACT) ||
                                         (state_q == ST_PRIME) || (state_q == ST_ACCUM));
   assign wbw_ev_s   = (state_q == ST_WRITE_BACK) && !wb_ack;

   always_comb begin
      stall_d = stall_q;
      wbw_d   = wbw_q;
      if (start_s) begin
         stall_d = 32'd0;
         wbw_d   = 32'd0;
      end else begin
         if (stall_ev_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
         end else begin
            stall_d = stall_q;
         end
         if (wbw_ev_s && (wbw_q != 32'hFFFF_FFFF)) begin
            wbw_d = wbw_q + 32'd1;
         end else begin
            wbw_d = wbw_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 32'd0;
         wbw_q   <= 32'd0;
      end else begin
         stall_q <= stall_d;
         wbw_q   <= wbw_d;
      end
   end

   assign stall_cycles   = stall_q;
   assign wb_wait_cycles = wbw_q;
`endif

endmodule

// File: tb/tb_smac_vol_seq.sv
// Directed self-checking bench for smac_vol_seq (KERNEL=3, W_BITS_MAX=8, MAX_FIL=64, PIPE_DEPTH=3).
module tb_smac_vol_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] cfg_wbits = 4'd0;
   logic [6:0] cfg_nfil = 7'd0;
   logic       core_stall_n = 1'b1;
   logic       wb_ack = 1'b1;
   logic       act_load, wei_load, acc_en, acc_clr, neg_en, wb, done, busy;
   logic [2:0] bit_idx;
   logic [3:0] tap_idx;
   logic [5:0] fil_idx;
`ifdef SMAC_SEQ_PERF_EN
   logic [31:0] stall_cycles, wb_wait_cycles;
`endif

   smac_vol_seq dut (
      .clk(clk), .rst(rst), .start(start), .cfg_wbits(cfg_wbits), .cfg_nfil(cfg_nfil),
      .core_stall_n(core_stall_n), .wb_ack(wb_ack),
      .act_load(act_load), .wei_load(wei_load), .acc_en(acc_en), .acc_clr(acc_clr),
      .neg_en(neg_en), .wb(wb), .done(done), .busy(busy),
      .bit_idx(bit_idx), .tap_idx(tap_idx), .fil_idx(fil_idx)
`ifdef SMAC_SEQ_PERF_EN
      , .stall_cycles(stall_cycles), .wb_wait_cycles(wb_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [0:255] act_l, wei_l, acc_l, neg_l, wb_l, done_l, clr_l, busy_l;
   int bit_l[256];
   int tap_l[256];
   int fil_l[256];

   function automatic int cnt(input logic [0:255] v, input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) n += int'(v[i]);
      return n;
   endfunction

   // Cycle 0 is the start cycle; inputs for cycle c are set at its falling edge, outputs logged 1 ns later.
   task automatic run_job(input logic [3:0] wbits, input logic [6:0] nfil, input int ncyc,
                          input int s0a, input int s0b, input int s1a, input int s1b,
                          input int aa, input int ab, input int rc, input int sc2);
      act_l = '0; wei_l = '0; acc_l = '0; neg_l = '0;
      wb_l = '0; done_l = '0; clr_l = '0; busy_l = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == sc2);
         if (c == 0) begin
            cfg_wbits = wbits; cfg_nfil = nfil;
         end else begin
            cfg_wbits = 4'd2; cfg_nfil = 7'd3;
         end
         core_stall_n = !((c >= s0a && c <= s0b) || (c >= s1a && c <= s1b));
         wb_ack = !(c >= aa && c <= ab);
         rst = (c == rc);
         #1;
         act_l[c] = act_load; wei_l[c] = wei_load; acc_l[c] = acc_en; neg_l[c] = neg_en;
         wb_l[c] = wb; done_l[c] = done; clr_l[c] = acc_clr; busy_l[c] = busy;
         bit_l[c] = int'(bit_idx); tap_l[c] = int'(tap_idx); fil_l[c] = int'(fil_idx);
      end
      @(negedge clk);
      start = 1'b0; rst = 1'b0; core_stall_n = 1'b1; wb_ack = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (acc_clr !== 1'b1) begin n_errors++; $display("FAIL rst_acc_clr: got %b want 1", acc_clr); end
      n_checks++; if ({act_load, wei_load, acc_en, neg_en, wb, done, busy} !== 7'b0) begin
         n_errors++; $display("FAIL rst_strobes: got %b want 0000000", {act_load, wei_load, acc_en, neg_en, wb, done, busy}); end
      n_checks++; if ({bit_idx, tap_idx, fil_idx} !== 13'd0) begin
         n_errors++; $display("FAIL rst_idx: got %0d/%0d/%0d want 0/0/0", bit_idx, tap_idx, fil_idx); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      run_job(4'd4, 7'd2, 92, -1, -1, -1, -1, -1, -1, -1, -1);
      n_checks++; if (act_l[1] !== 1'b1 || cnt(act_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL nom_act_load: cyc1=%b count=%0d want 1/1", act_l[1], cnt(act_l, 0, 255)); end
      n_checks++; if (wei_l[2] !== 1'b1 || acc_l[2] !== 1'b0) begin
         n_errors++; $display("FAIL nom_prime: wei=%b acc=%b want 1/0", wei_l[2], acc_l[2]); end
      n_checks++; if (cnt(acc_l & wei_l, 0, 255) !== 72) begin
         n_errors++; $display("FAIL nom_accum_cycles: got %0d want 72", cnt(acc_l & wei_l, 0, 255)); end
      n_checks++; if (cnt(acc_l, 0, 255) !== 78) begin
         n_errors++; $display("FAIL nom_acc_en_total: got %0d want 78", cnt(acc_l, 0, 255)); end
      n_checks++; if (cnt(neg_l, 0, 255) !== 18) begin
         n_errors++; $display("FAIL nom_neg_cnt: got %0d want 18", cnt(neg_l, 0, 255)); end
      n_checks++; if (neg_l[8] !== 1'b1 || neg_l[7] !== 1'b0 || bit_l[8] !== 3 || tap_l[9] !== 1) begin
         n_errors++; $display("FAIL nom_bit_seq: neg8=%b neg7=%b bit8=%0d tap9=%0d want 1/0/3/1", neg_l[8], neg_l[7], bit_l[8], tap_l[9]); end
      n_checks++; if (bit_l[40] !== 3 || tap_l[40] !== 8 || neg_l[40] !== 1'b1) begin
         n_errors++; $display("FAIL nom_last_tap: bit=%0d tap=%0d neg=%b want 3/8/1", bit_l[40], tap_l[40], neg_l[40]); end
      n_checks++; if (wb_l[44] !== 1'b1 || wb_l[87] !== 1'b1 || cnt(wb_l, 0, 255) !== 2) begin
         n_errors++; $display("FAIL nom_wb: wb44=%b wb87=%b count=%0d want 1/1/2", wb_l[44], wb_l[87], cnt(wb_l, 0, 255)); end
      n_checks++; if (done_l[88] !== 1'b1 || cnt(done_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL nom_done: cyc88=%b count=%0d want 1/1", done_l[88], cnt(done_l, 0, 255)); end
      n_checks++; if (clr_l[44] !== 1'b1 || clr_l[87] !== 1'b0 || clr_l[88] !== 1'b0 || clr_l[89] !== 1'b1) begin
         n_errors++; $display("FAIL nom_acc_clr: c44=%b c87=%b c88=%b c89=%b want 1/0/0/1", clr_l[44], clr_l[87], clr_l[88], clr_l[89]); end
      n_checks++; if (fil_l[44] !== 0 || fil_l[45] !== 1) begin
         n_errors++; $display("FAIL nom_fil_idx: c44=%0d c45=%0d want 0/1", fil_l[44], fil_l[45]); end
      n_checks++; if (busy_l[0] !== 1'b0 || busy_l[1] !== 1'b1 || busy_l[89] !== 1'b0) begin
         n_errors++; $display("FAIL nom_busy: c0=%b c1=%b c89=%b want 0/1/0", busy_l[0], busy_l[1], busy_l[89]); end
   endtask

   task automatic test_stall();
      run_job(4'd4, 7'd2, 97, 10, 14, 46, 47, -1, -1, -1, -1);
      n_checks++; if (cnt(wei_l | acc_l | neg_l, 10, 14) !== 0) begin
         n_errors++; $display("FAIL stall_strobes: got %0d active want 0", cnt(wei_l | acc_l | neg_l, 10, 14)); end
      n_checks++; if (bit_l[10] !== 1 || tap_l[10] !== 1 || bit_l[15] !== 1 || tap_l[15] !== 1) begin
         n_errors++; $display("FAIL stall_freeze: b10=%0d t10=%0d b15=%0d t15=%0d want 1/1/1/1", bit_l[10], tap_l[10], bit_l[15], tap_l[15]); end
      n_checks++; if (cnt(acc_l & wei_l, 0, 255) !== 72) begin
         n_errors++; $display("FAIL stall_accum_cycles: got %0d want 72", cnt(acc_l & wei_l, 0, 255)); end
      n_checks++; if (cnt(acc_l, 46, 48) !== 3 || wb_l[49] !== 1'b1) begin
         n_errors++; $display("FAIL stall_drain: acc=%0d wb49=%b want 3/1", cnt(acc_l, 46, 48), wb_l[49]); end
      n_checks++; if (done_l[93] !== 1'b1 || cnt(done_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL stall_done: cyc93=%b count=%0d want 1/1", done_l[93], cnt(done_l, 0, 255)); end
`ifdef SMAC_SEQ_PERF_EN
      n_checks++; if (stall_cycles !== 32'd5 || wb_wait_cycles !== 32'd0) begin
         n_errors++; $display("FAIL perf_stall: stall=%0d wbwait=%0d want 5/0", stall_cycles, wb_wait_cycles); end
`endif
   endtask

   task automatic test_clamp();
      run_job(4'd0, 7'd0, 85, -1, -1, -1, -1, -1, -1, -1, -1);
      n_checks++; if (cnt(acc_l & wei_l, 0, 255) !== 72 || cnt(neg_l, 0, 255) !== 9) begin
         n_errors++; $display("FAIL clamp_counts: accum=%0d neg=%0d want 72/9", cnt(acc_l & wei_l, 0, 255), cnt(neg_l, 0, 255)); end
      n_checks++; if (neg_l[12] !== 1'b1 || neg_l[11] !== 1'b0 || bit_l[12] !== 7) begin
         n_errors++; $display("FAIL clamp_msb: neg12=%b neg11=%b bit12=%0d want 1/0/7", neg_l[12], neg_l[11], bit_l[12]); end
      n_checks++; if (wb_l[80] !== 1'b1 || cnt(wb_l, 0, 255) !== 1 || done_l[81] !== 1'b1 || cnt(done_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL clamp_done: wb80=%b wbs=%0d done81=%b dones=%0d want 1/1/1/1", wb_l[80], cnt(wb_l, 0, 255), done_l[81], cnt(done_l, 0, 255)); end
   endtask

   task automatic test_sign_only();
      run_job(4'd1, 7'd1, 22, -1, -1, -1, -1, -1, -1, -1, -1);
      n_checks++; if (cnt(acc_l & wei_l, 0, 255) !== 9 || cnt(neg_l, 5, 13) !== 9 || cnt(neg_l, 0, 255) !== 9) begin
         n_errors++; $display("FAIL b1_neg: accum=%0d neg=%0d want 9/9", cnt(acc_l & wei_l, 0, 255), cnt(neg_l, 0, 255)); end
      n_checks++; if (done_l[18] !== 1'b1 || cnt(done_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL b1_done: cyc18=%b count=%0d want 1/1", done_l[18], cnt(done_l, 0, 255)); end
   endtask

   task automatic test_ack_wait();
      run_job(4'd4, 7'd2, 102, -1, -1, -1, -1, 44, 53, -1, -1);
      n_checks++; if (cnt(wb_l, 44, 54) !== 11 || wb_l[55] !== 1'b0 || cnt(wb_l, 0, 255) !== 12) begin
         n_errors++; $display("FAIL ack_wb_hold: hold=%0d wb55=%b total=%0d want 11/0/12", cnt(wb_l, 44, 54), wb_l[55], cnt(wb_l, 0, 255)); end
      n_checks++; if (fil_l[53] !== 0 || fil_l[54] !== 0 || fil_l[55] !== 1) begin
         n_errors++; $display("FAIL ack_fil_idx: c53=%0d c54=%0d c55=%0d want 0/0/1", fil_l[53], fil_l[54], fil_l[55]); end
      n_checks++; if (clr_l[53] !== 1'b0 || clr_l[54] !== 1'b1 || clr_l[55] !== 1'b0) begin
         n_errors++; $display("FAIL ack_acc_clr: c53=%b c54=%b c55=%b want 0/1/0", clr_l[53], clr_l[54], clr_l[55]); end
      n_checks++; if (done_l[98] !== 1'b1 || cnt(done_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL ack_done: cyc98=%b count=%0d want 1/1", done_l[98], cnt(done_l, 0, 255)); end
`ifdef SMAC_SEQ_PERF_EN
      n_checks++; if (stall_cycles !== 32'd0 || wb_wait_cycles !== 32'd10) begin
         n_errors++; $display("FAIL perf_wbwait: stall=%0d wbwait=%0d want 0/10", stall_cycles, wb_wait_cycles); end
`endif
   endtask

   task automatic test_reset_abort();
      run_job(4'd4, 7'd2, 30, -1, -1, -1, -1, -1, -1, 20, -1);
      n_checks++; if (busy_l[19] !== 1'b1 || bit_l[19] !== 2 || tap_l[19] !== 3) begin
         n_errors++; $display("FAIL abort_pre: busy=%b bit=%0d tap=%0d want 1/2/3", busy_l[19], bit_l[19], tap_l[19]); end
      n_checks++; if (clr_l[20] !== 1'b1 || busy_l[20] !== 1'b0 || wei_l[20] !== 1'b0 || acc_l[20] !== 1'b0) begin
         n_errors++; $display("FAIL abort_state: clr=%b busy=%b wei=%b acc=%b want 1/0/0/0", clr_l[20], busy_l[20], wei_l[20], acc_l[20]); end
      n_checks++; if (bit_l[20] !== 0 || tap_l[20] !== 0 || fil_l[20] !== 0) begin
         n_errors++; $display("FAIL abort_idx: %0d/%0d/%0d want 0/0/0", bit_l[20], tap_l[20], fil_l[20]); end
      n_checks++; if (cnt(done_l, 0, 255) !== 0 || cnt(wb_l, 0, 255) !== 0 || busy_l[29] !== 1'b0) begin
         n_errors++; $display("FAIL abort_quiet: done=%0d wb=%0d busy29=%b want 0/0/0", cnt(done_l, 0, 255), cnt(wb_l, 0, 255), busy_l[29]); end
   endtask

   task automatic test_back_to_back();
      run_job(4'd4, 7'd2, 92, -1, -1, -1, -1, -1, -1, -1, 30);
      n_checks++; if (done_l[88] !== 1'b1 || cnt(done_l, 0, 255) !== 1 || cnt(act_l, 0, 255) !== 1) begin
         n_errors++; $display("FAIL restart_done: cyc88=%b dones=%0d loads=%0d want 1/1/1", done_l[88], cnt(done_l, 0, 255), cnt(act_l, 0, 255)); end
      n_checks++; if (cnt(neg_l, 0, 255) !== 18 || wb_l[87] !== 1'b1) begin
         n_errors++; $display("FAIL restart_cfg: neg=%0d wb87=%b want 18/1", cnt(neg_l, 0, 255), wb_l[87]); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stall();
      test_clamp();
      test_sign_only();
      test_ack_wait();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
